// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU encodings: FSM states, Booth step ops, counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Counter must hold the value N itself, hence N+1 distinct codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twos_addsub_nbit.sv
`default_nettype none
// ============================================================================
// Module   : twos_addsub_nbit
// Brief    : Combinational W-bit ripple-carry adder/subtractor (S = X +/- Y).
// Revision : 1.0 - initial release
// ============================================================================
module twos_addsub_nbit #(
    parameter int W = 33
) (
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         sub,
    output logic [W-1:0] S
);

    logic [W-1:0] w_y;
    logic [W-1:0] w_c;

    // Subtraction is X + ~Y + 1, the +1 entering as carry-in.
    assign w_y    = Y ^ {W{sub}};
    assign w_c[0] = sub;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign S[i] = X[i] ^ w_y[i] ^ w_c[i];
        if (i < W - 1) begin : g_carry
            assign w_c[i+1] = (X[i] & w_y[i]) | (w_c[i] & (X[i] ^ w_y[i]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Brief    : Sequential signed NxN radix-2 Booth multiplier, one step per clock.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mult_seq
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P
);

    localparam int CW = cnt_width(N);

    state_t         r_state_q, w_state_d;
    logic [N:0]     r_acc_q,   w_acc_d;
    logic [N:0]     r_m_q,     w_m_d;
    logic [N-1:0]   r_q_q,     w_q_d;
    logic           r_q1_q,    w_q1_d;
    logic [CW-1:0]  r_cnt_q,   w_cnt_d;
    logic [2*N-1:0] r_p_q,     w_p_d;

    booth_op_t      w_op;
    logic [N:0]     w_sum;
    logic [N:0]     w_upd;

    always_comb begin
        w_op = OP_NOP;
        case ({r_q_q[0], r_q1_q})
            2'b01:   w_op = OP_ADD;
            2'b10:   w_op = OP_SUB;
            default: w_op = OP_NOP;
        endcase
    end

    twos_addsub_nbit #(.W(N + 1)) u_addsub (
        .X   (r_acc_q),
        .Y   (r_m_q),
        .sub (w_op == OP_SUB),
        .S   (w_sum)
    );

    assign w_upd = (w_op == OP_NOP) ? r_acc_q : w_sum;

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_m_d     = r_m_q;
        w_q_d     = r_q_q;
        w_q1_d    = r_q1_q;
        w_cnt_d   = r_cnt_q;
        w_p_d     = r_p_q;
        busy      = (r_state_q == S_RUN);
        done      = (r_state_q == S_DONE);

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_d = S_RUN;
                    w_m_d     = {A[N-1], A};
                    w_acc_d   = '0;
                    w_q_d     = B;
                    w_q1_d    = 1'b0;
                    w_cnt_d   = CW'(N);
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt_q == '0) begin
                    w_state_d = S_DONE;
                    w_p_d     = {r_acc_q[N-1:0], r_q_q};
                end else begin
                    // Arithmetic right shift of {Acc, Q, q_1} after the add/sub.
                    w_acc_d = {w_upd[N], w_upd[N:1]};
                    w_q_d   = {w_upd[0], r_q_q[N-1:1]};
                    w_q1_d  = r_q_q[0];
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_acc_q   <= '0;
            r_m_q     <= '0;
            r_q_q     <= '0;
            r_q1_q    <= 1'b0;
            r_cnt_q   <= '0;
            r_p_q     <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_m_q     <= w_m_d;
            r_q_q     <= w_q_d;
            r_q1_q    <= w_q1_d;
            r_cnt_q   <= w_cnt_d;
            r_p_q     <= w_p_d;
        end
    end

    assign P = r_p_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_seq
// Brief    : Scoreboard bench for booth_mult_seq with N=32 and random operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   A = '0;
    logic [N-1:0]   B = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P;

    always #5 clk = ~clk;

    booth_mult_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    typedef struct {
        logic [2*N-1:0] p;
        int             c;
    } exp_t;

    exp_t           exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic           rst_was = 1'b1;
    logic [2*N-1:0] last_p = '0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_was <= rst;
    end

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Monitor: pops the scoreboard on every done pulse; checks P is held otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected P=%h cyc=%0d", P, cyc);
            end else begin
                e = exp_q.pop_front();
                if (P !== e.p) begin
                    errors++;
                    $display("FAIL product actual=%h expected=%h", P, e.p);
                end
                checks++;
                if (cyc - e.c != N + 1) begin
                    errors++;
                    $display("FAIL latency actual=%0d expected=%0d", cyc - e.c, N + 1);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done actual=%b expected=0", busy);
                end
            end
        end else if (!rst_was) begin
            checks++;
            if (P !== last_p) begin
                errors++;
                $display("FAIL p_stable actual=%h expected=%h", P, last_p);
            end
        end
        last_p = P;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Presents one start cycle; a request is only expected to land when idle/done.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        A     = a;
        B     = b;
        start = 1'b1;
        if (!busy) begin
            e.p = prod(a, b);
            e.c = cyc + 1;
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout done=%b required=1", done);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_p", P, 64'd0);
        rst = 1'b0;
        tick();

        issue(32'd7, -32'sd3);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        drain();
        issue(32'h8000_0000, 32'h8000_0000);
        drain();
        issue(32'h8000_0000, 32'h7FFF_FFFF);
        drain();
        issue(32'h7FFF_FFFF, 32'h8000_0000);
        drain();
        issue(32'd0, 32'd0);
        drain();
        issue(32'd0, 32'hDEAD_BEEF);
        drain();

        // Start while busy must be ignored, then a back-to-back start in DONE.
        issue(32'd5, 32'd6);
        repeat (5) tick();
        chk("busy_mid_run", {63'd0, busy}, 64'd1);
        issue(32'd9, 32'd9);
        wait_done();
        chk("p_first_result", P, 64'd30);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("busy_back_to_back", {63'd0, busy}, 64'd1);
        repeat (10) tick();
        chk("p_held_in_run", P, 64'd30);
        drain();
        chk("p_minus1_squared", P, 64'd1);

        // Reset during RUN discards the result and clears P.
        issue(32'd100, 32'd3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_p", P, 64'd0);
        repeat (40) tick();
        issue(32'd2, -32'sd2);
        drain();
        chk("p_after_reset_run", P, 64'hFFFF_FFFF_FFFF_FFFC);

        for (int i = 0; i < 50; i++) begin
            issue($urandom, $urandom);
            A = $urandom;
            B = $urandom;
            if (i % 3 == 0) begin
                wait_done();
            end else begin
                drain();
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        drain();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
